uart_pkt_rx: RTL and testbench
==============================

# uart_pkt_rx

Fixed-length UART packet receiver. Deserialises 8N1 serial bytes on `uart_rxd`, collects a packet of eight consecutive bytes, and presents them in parallel on `uart_data0`..`uart_data7` with a one-cycle `packet_done` strobe. It sits behind the board UART pin and feeds the DDS control/register logic.

## Interface
- `CLK_FREQ`, 50_000_000, system clock frequency in Hz
- `UART_BPS`, 115200, baud rate
- `PKT_LEN`, 8, bytes per packet (outputs fixed at 8; parameter exists for the counter width only)
- `TIMEOUT_BITS`, 20, inter-byte idle limit in bit periods (used only with the timeout feature)

- `clk`  input  1  system clock, all logic on rising edge
- `rst_n`  input  1  reset; asynchronous, active-low
- `uart_rxd`  input  1  serial data, idle high, asynchronous to `clk`
- `packet_done`  output  1  one-cycle pulse when a full packet is latched
- `uart_data0`..`uart_data7`  output  8 each  packet bytes; `uart_data0` is the first byte received

## Operation
- `BPS_CNT = CLK_FREQ/UART_BPS` (434 at defaults); bit counter counts 0..BPS_CNT-1.
- `uart_rxd` passes through a 2-FF synchroniser, then one more register for edge detect.
- Byte FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on a falling edge of the synchronised line.
  - START: at count BPS_CNT/2, if the line is low go to DATA, else return to IDLE (glitch rejection).
  - DATA: sample at mid-bit, LSB first, 8 bits, then go to STOP.
  - STOP: at mid-bit, a high line gives a valid byte (1-cycle internal `byte_valid`); a low line is a framing error, the byte is discarded, and the FSM waits for the line to go high, then returns to IDLE.
  - Return to IDLE immediately after the stop-bit sample, so a new start bit is accepted from the second half of the stop bit.
- Packet assembly:
  - A byte index 0..7 increments on each `byte_valid`, and the byte is stored in the internal buffer slot indexed.
  - On the 8th valid byte, all eight buffer slots plus the incoming byte are copied to `uart_data0..7`, `packet_done` pulses, and the index wraps to 0.
- Outputs hold their value until the next complete packet; partial packets never modify them.
- Reset (any time, including mid-byte or mid-packet): FSM goes to IDLE, and counters, index, buffer, `packet_done` and all `uart_data*` go to 0. The synchroniser resets to 1.

## Timing
- Start-edge detect latency: 3 `clk` cycles after the pin falls (2 sync stages plus the edge register).
- `byte_valid` fires about 9.5 bit periods after the start edge (~82.5 µs at defaults).
- `packet_done` and the new `uart_data*` values appear together, 1 cycle after the 8th `byte_valid`. `packet_done` is high for exactly 1 cycle.
- Back-to-back bytes with zero idle are supported. Any gap length is allowed unless the timeout feature is enabled.
- A framing error does not advance the index.

## Configuration
- `UART_PKT_TIMEOUT_EN` defined:
  - An idle counter runs while the index is non-zero and the FSM is in IDLE.
  - When it reaches `TIMEOUT_BITS*BPS_CNT` cycles, the index resets to 0 and the partial packet is dropped.
  - Outputs and `packet_done` are unaffected.
- Macro undefined: no idle counter; a partial packet waits indefinitely.

## Structure
- Shared package `uart_pkt_pkg`:
  - `localparam` defaults (CLK_FREQ, UART_BPS, PKT_LEN)
  - byte-FSM state enum `uart_rx_state_t` (IDLE, START, DATA, STOP)
  - `typedef logic [7:0] uart_byte_t`
- One sub-module, `uart_byte_rx`, containing the synchroniser, byte FSM and bit counter. It outputs `byte_valid` and `byte_data`.
- Top level holds the packet index, buffer, output registers and optional timeout.

## Test plan
- Reset released at 200 ns. Send bytes 0x10..0x17, 8680 ns/bit, 1000 ns gaps -> exactly one `packet_done` pulse; `uart_data0`=0x10 … `uart_data7`=0x17.
- Send 16 back-to-back bytes 0x00..0x0F -> two pulses. After the first, data0..7 = 0x00..0x07; after the second, 0x08..0x0F.
- 3 µs low glitch on idle line, then 8 valid bytes 0xA0..0xA7 -> glitch ignored; one pulse with 0xA0..0xA7.
- Byte 0x55 with stop bit forced low, followed by 8 valid bytes 0x20..0x27 -> erroneous byte not counted; one pulse with 0x20..0x27.
- Assert `rst_n` low during the 4th byte, release, send 0x30..0x37 -> all outputs 0 during reset; one pulse with 0x30..0x37.
- With `UART_PKT_TIMEOUT_EN`: send 3 bytes, idle 25 bit periods, send 0x40..0x47 -> one pulse with 0x40..0x47. Without the macro, the same stimulus pulses after the 5th new byte.

Source files
------------

// File: rtl/uart_pkt_pkg.sv
// uart_pkt_pkg
// Shared definitions for the UART packet receiver:
//   CLK_FREQ / UART_BPS / PKT_LEN : default configuration values
//   uart_rx_state_t               : byte-level receive FSM states
//   uart_byte_t                   : one received byte
package uart_pkt_pkg;

  localparam int CLK_FREQ = 50_000_000;
  localparam int UART_BPS = 115_200;
  localparam int PKT_LEN  = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_rx_state_t;

  typedef logic [7:0] uart_byte_t;

endpackage

// File: rtl/uart_byte_rx.sv
// uart_byte_rx
// 8N1 byte deserialiser: 2-FF synchroniser plus edge register, bit-period
// counter and the IDLE/START/DATA/STOP byte FSM.
// Ports:
//   clk_i          system clock, rising edge
//   rst_n_i        asynchronous active-low reset
//   rxd_i          raw serial line (idle high, asynchronous to clk_i)
//   idle_o         FSM is in IDLE (only present with UART_PKT_TIMEOUT_EN)
//   byte_valid_o   one-cycle strobe: byte_data_o holds a correctly framed byte
//   byte_data_o    last received byte, LSB received first
// Configuration macro: UART_PKT_TIMEOUT_EN adds the idle_o port.
module uart_byte_rx #(
  parameter int BPS_CNT = 434
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       rxd_i,
`ifdef UART_PKT_TIMEOUT_EN
  output logic       idle_o,
`endif
  output logic       byte_valid_o,
  output logic [7:0] byte_data_o
);
  import uart_pkt_pkg::*;

  localparam int CNT_W = (BPS_CNT > 2) ? $clog2(BPS_CNT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BPS_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_MID = CNT_W'(BPS_CNT / 2);

  logic             rxd_s1_q, rxd_s2_q, rxd_s3_q;
  logic             fall_edge;
  logic             mid_bit;
  uart_rx_state_t   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  uart_byte_t       shift_q, shift_d;
  logic             frame_err_q, frame_err_d;
  logic             valid_q, valid_d;

  // Synchroniser resets to the idle (high) line level so that reset release
  // never looks like a start edge.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rxd_s1_q <= 1'b1;
      rxd_s2_q <= 1'b1;
      rxd_s3_q <= 1'b1;
    end else begin
      rxd_s1_q <= rxd_i;
      rxd_s2_q <= rxd_s1_q;
      rxd_s3_q <= rxd_s2_q;
    end
  end

  assign fall_edge = rxd_s3_q & ~rxd_s2_q;
  assign mid_bit   = (cnt_q == CNT_MID);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      valid_q     <= valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    frame_err_d = frame_err_q;
    valid_d     = 1'b0;

    // The counter free-runs through a whole frame; because START hands over
    // to DATA at the mid count without reloading, every later mid count lands
    // in the middle of the following bit.
    if (state_q == IDLE) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        frame_err_d = 1'b0;
        if (fall_edge) begin
          state_d = START;
        end
      end
      START: begin
        if (mid_bit) begin
          if (!rxd_s2_q) begin
            state_d   = DATA;
            bit_idx_d = '0;
          end else begin
            state_d = IDLE;  // short low glitch, not a start bit
          end
        end
      end
      DATA: begin
        if (mid_bit) begin
          shift_d   = {rxd_s2_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (frame_err_q) begin
          // Bad stop bit: hold off until the line is idle again.
          if (rxd_s2_q) begin
            state_d     = IDLE;
            frame_err_d = 1'b0;
          end
        end else if (mid_bit) begin
          if (rxd_s2_q) begin
            valid_d = 1'b1;
            state_d = IDLE;  // leaves half a stop bit to catch the next start
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef UART_PKT_TIMEOUT_EN
  assign idle_o = (state_q == IDLE);
`endif
  assign byte_valid_o = valid_q;
  assign byte_data_o  = shift_q;

endmodule

// File: rtl/uart_pkt_rx.sv
// uart_pkt_rx
// Fixed-length UART packet receiver. Collects PKT_LEN consecutive valid
// bytes from uart_byte_rx and presents them in parallel with a one-cycle
// packet_done strobe. Outputs hold until the next complete packet.
// Ports:
//   clk                     system clock, rising edge
//   rst_n                   asynchronous active-low reset
//   uart_rxd                serial input, idle high
//   packet_done             one-cycle pulse when uart_data* are updated
//   uart_data0..uart_data7  packet bytes, uart_data0 received first
// Configuration macro: UART_PKT_TIMEOUT_EN drops a partial packet after
// TIMEOUT_BITS bit periods of idle line between bytes.
module uart_pkt_rx #(
  parameter int CLK_FREQ     = uart_pkt_pkg::CLK_FREQ,
  parameter int UART_BPS     = uart_pkt_pkg::UART_BPS,
  parameter int PKT_LEN      = uart_pkt_pkg::PKT_LEN,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rxd,
  output logic       packet_done,
  output logic [7:0] uart_data0,
  output logic [7:0] uart_data1,
  output logic [7:0] uart_data2,
  output logic [7:0] uart_data3,
  output logic [7:0] uart_data4,
  output logic [7:0] uart_data5,
  output logic [7:0] uart_data6,
  output logic [7:0] uart_data7
);
  import uart_pkt_pkg::*;

  localparam int BPS_CNT = CLK_FREQ / UART_BPS;
  localparam int IDX_W   = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PKT_LEN - 1);

  // The output port set is fixed at eight bytes.
  if (PKT_LEN < 2 || PKT_LEN > 8 || TIMEOUT_BITS < 1) begin : g_bad_cfg
    $error("uart_pkt_rx: PKT_LEN must be 2..8 and TIMEOUT_BITS >= 1");
  end

  logic                  byte_valid;
  uart_byte_t            byte_data;
  logic [IDX_W-1:0]      idx_q, idx_d;
  uart_byte_t [7:0]      pkt_buf_q, pkt_buf_d;
  uart_byte_t [7:0]      data_q, data_d;
  logic                  done_q, done_d;

`ifdef UART_PKT_TIMEOUT_EN
  localparam int TO_LIMIT = TIMEOUT_BITS * BPS_CNT;
  localparam int TO_W     = $clog2(TO_LIMIT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_LIMIT - 1);

  logic            rx_idle;
  logic [TO_W-1:0] idle_cnt_q, idle_cnt_d;
  logic            timeout_hit;
`endif

  uart_byte_rx #(
    .BPS_CNT(BPS_CNT)
  ) u_byte_rx (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .rxd_i        (uart_rxd),
`ifdef UART_PKT_TIMEOUT_EN
    .idle_o       (rx_idle),
`endif
    .byte_valid_o (byte_valid),
    .byte_data_o  (byte_data)
  );

`ifdef UART_PKT_TIMEOUT_EN
  // Counts idle cycles only between bytes of a partially received packet.
  always_comb begin
    idle_cnt_d  = '0;
    timeout_hit = 1'b0;
    if (rx_idle && (idx_q != '0) && !byte_valid) begin
      if (idle_cnt_q == TO_LAST) begin
        timeout_hit = 1'b1;
      end else begin
        idle_cnt_d = idle_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end
`endif

  always_comb begin
    idx_d     = idx_q;
    pkt_buf_d = pkt_buf_q;
    data_d    = data_q;
    done_d    = 1'b0;

    if (byte_valid) begin
      if (idx_q == IDX_LAST) begin
        // Last byte goes straight to the output alongside the buffered ones.
        data_d        = pkt_buf_q;
        data_d[idx_q] = byte_data;
        done_d        = 1'b1;
        idx_d         = '0;
      end else begin
        pkt_buf_d[idx_q] = byte_data;
        idx_d            = idx_q + 1'b1;
      end
    end
`ifdef UART_PKT_TIMEOUT_EN
    else if (timeout_hit) begin
      idx_d = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q     <= '0;
      pkt_buf_q <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      pkt_buf_q <= pkt_buf_d;
      data_q    <= data_d;
      done_q    <= done_d;
    end
  end

  assign packet_done = done_q;
  assign uart_data0  = data_q[0];
  assign uart_data1  = data_q[1];
  assign uart_data2  = data_q[2];
  assign uart_data3  = data_q[3];
  assign uart_data4  = data_q[4];
  assign uart_data5  = data_q[5];
  assign uart_data6  = data_q[6];
  assign uart_data7  = data_q[7];

endmodule

// File: tb/tb_uart_pkt_rx.sv
// tb_uart_pkt_rx
// Self-checking bench for uart_pkt_rx. The baud rate is raised so one bit
// is 16 clocks, keeping each scenario short. A reference model groups the
// correctly framed bytes that were sent into packets of eight; a monitor
// records every packet_done snapshot and compares them in order.
// Honours UART_PKT_TIMEOUT_EN in its expectations.
`timescale 1ns/1ps
module tb_uart_pkt_rx;
  localparam int CLK_FREQ = 50_000_000;
  localparam int UART_BPS = 3_125_000;
  localparam int BPS_CNT  = CLK_FREQ / UART_BPS;
  localparam int CLK_NS   = 20;
  localparam int BIT_NS   = BPS_CNT * CLK_NS;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b1;
  logic       uart_rxd = 1'b1;
  logic       packet_done;
  logic [7:0] uart_data0, uart_data1, uart_data2, uart_data3;
  logic [7:0] uart_data4, uart_data5, uart_data6, uart_data7;

  int vectors     = 0;
  int miscompares = 0;

  logic [63:0] obs_q[$];   // snapshots taken on packet_done
  logic [63:0] exp_q[$];   // packets predicted by the model
  logic [7:0]  pend_q[$];  // model: valid bytes of the open packet
  logic [63:0] last_pkt = '0;
  int          long_pulses = 0;
  int          hold_viol   = 0;
  logic        done_prev   = 1'b0;
  logic [63:0] data_prev   = '0;

  wire [63:0] data_bus = {uart_data7, uart_data6, uart_data5, uart_data4,
                          uart_data3, uart_data2, uart_data1, uart_data0};

  uart_pkt_rx #(
    .CLK_FREQ    (CLK_FREQ),
    .UART_BPS    (UART_BPS),
    .PKT_LEN     (8),
    .TIMEOUT_BITS(20)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .uart_rxd   (uart_rxd),
    .packet_done(packet_done),
    .uart_data0 (uart_data0),
    .uart_data1 (uart_data1),
    .uart_data2 (uart_data2),
    .uart_data3 (uart_data3),
    .uart_data4 (uart_data4),
    .uart_data5 (uart_data5),
    .uart_data6 (uart_data6),
    .uart_data7 (uart_data7)
  );

  always #(CLK_NS/2) clk = ~clk;

  // Monitor: records packets, pulses longer than one cycle, and output
  // changes that happen without a packet_done.
  always @(negedge clk) begin
    if (packet_done) begin
      obs_q.push_back(data_bus);
      if (done_prev) long_pulses++;
    end else if (rst_n && (data_bus !== data_prev)) begin
      hold_viol++;
    end
    done_prev = packet_done;
    data_prev = data_bus;
  end

  // Reference model: every correctly framed byte joins the open packet;
  // eight of them form a packet in arrival order.
  task automatic model_byte(input logic [7:0] b);
    logic [63:0] p;
    pend_q.push_back(b);
    if (pend_q.size() == 8) begin
      p = '0;
      for (int k = 0; k < 8; k++) p[8*k +: 8] = pend_q[k];
      exp_q.push_back(p);
      last_pkt = p;
      pend_q.delete();
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    uart_rxd = 1'b0;
    #(BIT_NS);
    for (int k = 0; k < 8; k++) begin
      uart_rxd = b[k];
      #(BIT_NS);
    end
    uart_rxd = stop_bit;
    #(BIT_NS);
    uart_rxd = 1'b1;
  endtask

  task automatic send_good(input logic [7:0] b, input int gap_ns);
    send_byte(b, 1'b1);
    model_byte(b);
    if (gap_ns > 0) #(gap_ns);
  endtask

  task automatic test_reset();
    #100;
    vectors++;
    if (packet_done !== 1'b0 || data_bus !== 64'h0) begin
      miscompares++;
      $display("FAIL reset_hold: done=%b data=%h, required done=0 data=0", packet_done, data_bus);
    end
    #100;
    rst_n = 1'b1;
    #(4*BIT_NS);
    vectors++;
    if (obs_q.size() != 0 || data_bus !== 64'h0) begin
      miscompares++;
      $display("FAIL reset_release: pulses=%0d data=%h, required 0 pulses data=0", obs_q.size(), data_bus);
    end
    $display("reset: data=%h done=%b", data_bus, packet_done);
  endtask

  task automatic test_basic();
    logic [63:0] o, e;
    for (int i = 0; i < 8; i++) send_good(8'(8'h10 + i), 1000);
    #(2*BIT_NS);
    vectors++;
    if (obs_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL basic_count: pulses=%0d, required %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      vectors++;
      $display("basic pkt: got=%h want=%h", o, e);
      if (o !== e) begin
        miscompares++;
        $display("FAIL basic_pkt: got=%h, required %h", o, e);
      end
    end
    obs_q.delete(); exp_q.delete();
    vectors++;
    if (uart_data0 !== 8'h10 || uart_data7 !== 8'h17) begin
      miscompares++;
      $display("FAIL basic_const: data0=%h data7=%h, required 10 and 17", uart_data0, uart_data7);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] o, e;
    for (int i = 0; i < 16; i++) send_good(8'(i), 0);
    #(2*BIT_NS);
    vectors++;
    if (obs_q.size() != 2 || exp_q.size() != 2) begin
      miscompares++;
      $display("FAIL b2b_count: pulses=%0d, required %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      vectors++;
      $display("b2b pkt: got=%h want=%h", o, e);
      if (o !== e) begin
        miscompares++;
        $display("FAIL b2b_pkt: got=%h, required %h", o, e);
      end
    end
    obs_q.delete(); exp_q.delete();
    vectors++;
    if (data_bus !== 64'h0F0E0D0C0B0A0908) begin
      miscompares++;
      $display("FAIL b2b_hold: data=%h, required 0f0e0d0c0b0a0908", data_bus);
    end
  endtask

  task automatic test_glitch();
    logic [63:0] o, e;
    uart_rxd = 1'b0;
    #(100);              // about 5 clocks, well under half a bit
    uart_rxd = 1'b1;
    #(2*BIT_NS);
    for (int i = 0; i < 8; i++) send_good(8'(8'hA0 + i), 200);
    #(2*BIT_NS);
    vectors++;
    if (obs_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL glitch_count: pulses=%0d, required %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      vectors++;
      $display("glitch pkt: got=%h want=%h", o, e);
      if (o !== e) begin
        miscompares++;
        $display("FAIL glitch_pkt: got=%h, required %h", o, e);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_framing();
    logic [63:0] o, e;
    send_byte(8'h55, 1'b0);  // not given to the model: must be discarded
    #(BIT_NS);
    for (int i = 0; i < 8; i++) send_good(8'(8'h20 + i), 500);
    #(2*BIT_NS);
    vectors++;
    if (obs_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL frame_count: pulses=%0d, required %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      vectors++;
      $display("frame pkt: got=%h want=%h", o, e);
      if (o !== e) begin
        miscompares++;
        $display("FAIL frame_pkt: got=%h, required %h", o, e);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid();
    logic [63:0] o, e;
    for (int i = 0; i < 3; i++) send_good(8'(8'h90 + i), 300);
    // Fourth byte: start bit and three data bits, then reset.
    uart_rxd = 1'b0;
    #(BIT_NS);
    for (int k = 0; k < 3; k++) begin
      uart_rxd = k[0];
      #(BIT_NS);
    end
    rst_n = 1'b0;
    pend_q.delete();
    last_pkt = '0;
    #(5*CLK_NS);
    vectors++;
    if (packet_done !== 1'b0 || data_bus !== 64'h0) begin
      miscompares++;
      $display("FAIL midrst_zero: done=%b data=%h, required done=0 data=0", packet_done, data_bus);
    end
    uart_rxd = 1'b1;
    #(3*BIT_NS);
    rst_n = 1'b1;
    #(2*BIT_NS);
    for (int i = 0; i < 8; i++) send_good(8'(8'h30 + i), 0);
    #(2*BIT_NS);
    vectors++;
    if (obs_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL midrst_count: pulses=%0d, required %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      vectors++;
      $display("midrst pkt: got=%h want=%h", o, e);
      if (o !== e) begin
        miscompares++;
        $display("FAIL midrst_pkt: got=%h, required %h", o, e);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_timeout();
    logic [63:0] o, e;
    for (int i = 0; i < 3; i++) send_good(8'(8'h50 + i), 0);
    #(25*BIT_NS);
`ifdef UART_PKT_TIMEOUT_EN
    pend_q.delete();     // idle longer than the limit drops the partial packet
`endif
    for (int i = 0; i < 8; i++) send_good(8'(8'h40 + i), 0);
    #(2*BIT_NS);
    vectors++;
    if (obs_q.size() != 1 || exp_q.size() != 1) begin
      miscompares++;
      $display("FAIL timeout_count: pulses=%0d, required %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      vectors++;
      $display("timeout pkt: got=%h want=%h", o, e);
      if (o !== e) begin
        miscompares++;
        $display("FAIL timeout_pkt: got=%h, required %h", o, e);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    logic [63:0] o, e;
    logic [7:0]  b;
    for (int i = 0; i < 40; i++) begin
      b = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 9) == 0) begin
        send_byte(b, 1'b0);
        #(BIT_NS);
      end else begin
        send_good(b, 0);
      end
      #($urandom_range(0, 3*BIT_NS));
    end
    #(2*BIT_NS);
    vectors++;
    if (obs_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL rand_count: pulses=%0d, required %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      vectors++;
      $display("rand pkt: got=%h want=%h", o, e);
      if (o !== e) begin
        miscompares++;
        $display("FAIL rand_pkt: got=%h, required %h", o, e);
      end
    end
    obs_q.delete(); exp_q.delete();
    vectors++;
    if (data_bus !== last_pkt) begin
      miscompares++;
      $display("FAIL rand_hold: data=%h, required %h", data_bus, last_pkt);
    end
  endtask

  task automatic test_strobe_rules();
    vectors++;
    if (long_pulses != 0) begin
      miscompares++;
      $display("FAIL done_width: long pulses=%0d, required 0", long_pulses);
    end
    vectors++;
    if (hold_viol != 0) begin
      miscompares++;
      $display("FAIL output_hold: unstrobed changes=%0d, required 0", hold_viol);
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_glitch();
    test_framing();
    test_reset_mid();
    test_timeout();
    test_random();
    test_strobe_rules();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
